crc32_checker: RTL
==================

// Module: crc32_checker
// PURPOSE
//  Receive-side companion to the CRC-32 generator: consumes a framed byte stream whose last 4 bytes are the FCS
//  (LSB first) and reports pass/fail per frame. CRC-32/IEEE 802.3: reflected poly 0xEDB88320, init 0xFFFFFFFF,
//  good-frame residue 0xDEBB20E3 (register before final XOR). Sits between the byte deserialiser and frame consumer.
// PARAMETERS
//  MIN_LEN   5    minimum legal frame length in bytes incl. FCS; must be >= 5
//  LEN_W     16   width of frame length counter
// PORTS
//  clk40        in   1      system clock, all logic on rising edge
//  rst          in   1      synchronous reset, active-high
//  din          in   8      input byte
//  din_valid    in   1      din qualifier; beats with din_valid=0 are ignored entirely
//  din_sof      in   1      first byte of frame (qualified by din_valid)
//  din_eof      in   1      last byte of frame, i.e. FCS MSB (qualified by din_valid)
//  crc_done     out  1      one-cycle pulse: frame status valid
//  crc_ok       out  1      frame passed (valid with crc_done)
//  crc_err      out  2      0 none, 1 CRC mismatch, 2 runt, 3 abort/overflow (valid with crc_done)
//  frame_len    out  LEN_W  bytes in frame incl. FCS (valid with crc_done)
//  crc_residue  out  32     raw CRC register at end of frame (debug)
//  dout/dout_valid/dout_sof/dout_eof  out 8/1/1/1   only with CRC_STRIP_EN, see CONFIGURATION
// BEHAVIOUR
//  - Reset: all outputs 0, CRC reg = 0xFFFFFFFF, len = 0, state IDLE. Reset mid-frame discards frame, no crc_done.
//  - FSM IDLE: valid&sof -> ACTIVE (CRC reg seeded with init then updated with din, len=1); valid w/o sof dropped.
//  - ACTIVE: each valid beat updates CRC reg (LSB-first, 8 bits per cycle), len+1.
//    valid&eof -> IDLE, status registered; crc_done asserts cycle after eof beat (latency 1).
//    valid&sof (no eof) mid-frame -> abort: crc_done with err=3, frame_len = bytes so far (excl. new byte),
//    crc_ok=0; new frame starts on that same beat (CRC reseeded, len=1).
//  - sof&eof on same beat in IDLE: one-byte frame -> crc_done, err=2.
//  - Pass: len >= MIN_LEN and final reg == 0xDEBB20E3 -> crc_ok=1, err=0.
//  - Error priority: 3 (abort or len counter saturated at 2^LEN_W-1) > 2 (len < MIN_LEN) > 1 (residue mismatch).
//  - len counter saturates, never wraps; saturation latches overflow flag until frame end.
//  - crc_ok/crc_err/frame_len/crc_residue hold last values until next crc_done.
// CONFIGURATION
//  CRC_STRIP_EN defined: 4-byte delay line; payload forwarded with FCS removed. Once 4 bytes of the frame are
//   buffered, each further valid beat outputs the oldest byte next cycle (dout_valid=1). dout_sof on first
//   payload byte; dout_eof on last payload byte, coincident with crc_done. Abort: delay line flushed, no dout_eof.
//   Frames <= 4 bytes emit no dout. Reset clears delay line and dout* to 0.
//  CRC_STRIP_EN undefined: no dout* ports, no delay line; status outputs identical.
// STRUCTURE
//  - crc32_pkg: CRC_POLY_REFL 32'hEDB88320, CRC_INIT 32'hFFFFFFFF, CRC_RESIDUE 32'hDEBB20E3,
//    CRC_XOROUT 32'hFFFFFFFF, ERR_NONE/ERR_CRC/ERR_RUNT/ERR_ABORT codes, FSM state encodings.
//  - Sub-module crc32_byte_step: combinational next_crc = f(crc[31:0], byte[7:0]); shared with the generator.
//  - Top: FSM, length counter, status registers, optional strip delay line.
// TESTING
//  1. Good frame: 31 32 33 34 35 36 37 38 39 26 39 F4 CB (sof 0x31, eof 0xCB) -> crc_done 1 cycle after eof,
//     crc_ok=1, err=0, frame_len=13, crc_residue=0xDEBB20E3.
//  2. Same frame, last byte 0xCA -> crc_ok=0, err=1, frame_len=13.
//  3. Runt: 31 32 33 with sof/eof -> err=2, len=3; single byte sof&eof -> err=2, len=1.
//  4. Abort: 6 bytes, then sof on frame 1 byte -> crc_done err=3 len=6; frame 1 completes -> ok=1, len=13.
//  5. Frame 1 with random din_valid gaps and a reset pulse in a prior frame -> result identical to (1);
//     reset-interrupted frame produces no crc_done.
//  6. CRC_STRIP_EN build, frame 1 -> dout 31..39 (9 beats), dout_sof on 0x31, dout_eof on 0x39 with crc_done.

Source files
------------

// File: rtl/crc32_pkg.sv
// -----------------------------------------------------------------------------
// crc32_pkg
// Shared constants and types for the CRC-32/IEEE 802.3 generator and checker.
//   CRC_POLY_REFL : reflected polynomial, processed LSB first
//   CRC_INIT      : register seed at start of every frame
//   CRC_RESIDUE   : register value after a good frame including its FCS
//   CRC_XOROUT    : final XOR applied when the generator emits the FCS
//   crc_err_e     : per-frame status code reported by the checker
//   crc_state_e   : checker frame-tracking states
// Macro: CRC_STRIP_EN (consumed by crc32_checker, not by this package).
// -----------------------------------------------------------------------------
package crc32_pkg;

  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam logic [31:0] CRC_XOROUT    = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_CRC   = 2'd1,
    ERR_RUNT  = 2'd2,
    ERR_ABORT = 2'd3
  } crc_err_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } crc_state_e;

  // Turns a running register into the value transmitted as FCS.
  function automatic logic [31:0] crc_final(input logic [31:0] crcReg);
    return crcReg ^ CRC_XOROUT;
  endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// -----------------------------------------------------------------------------
// crc32_byte_step
// Purely combinational single-byte CRC-32 update, bit-serial LSB first,
// unrolled to 8 bits. Shared by the generator and the checker.
//   crc_i  [31:0] : current CRC register
//   data_i [7:0]  : byte to absorb
//   crc_o  [31:0] : register after absorbing data_i
// -----------------------------------------------------------------------------
module crc32_byte_step
  import crc32_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  // Reflected form: XOR the byte into the low end, then shift right eight
  // times, folding the polynomial in whenever a one falls out of bit 0.
  always_comb begin
    crc_o = crc_i ^ {24'h000000, data_i};
    for (int i = 0; i < 8; i++) begin
      crc_o = crc_o[0] ? ((crc_o >> 1) ^ CRC_POLY_REFL) : (crc_o >> 1);
    end
  end

endmodule

// File: rtl/crc32_checker.sv
// -----------------------------------------------------------------------------
// crc32_checker
// Receive-side CRC-32 checker. Consumes framed bytes whose last four bytes are
// the FCS (LSB first) and reports one status per frame.
//   clk40       in  : system clock, rising edge
//   rst         in  : synchronous active-high reset
//   din[7:0]    in  : input byte, qualified by din_valid
//   din_valid   in  : beat qualifier; invalid beats are ignored
//   din_sof     in  : first byte of frame
//   din_eof     in  : last byte of frame (FCS MSB)
//   crc_done    out : one-cycle pulse, status valid
//   crc_ok      out : frame passed
//   crc_err     out : 0 none, 1 CRC mismatch, 2 runt, 3 abort/overflow
//   frame_len   out : bytes in frame including FCS
//   crc_residue out : raw CRC register at end of frame
//   dout/dout_valid/dout_sof/dout_eof out : payload with FCS stripped,
//                     present only when CRC_STRIP_EN is defined
// Macro CRC_STRIP_EN enables the 4-byte FCS-stripping delay line.
// -----------------------------------------------------------------------------
module crc32_checker
  import crc32_pkg::*;
#(
  parameter int MIN_LEN = 5,
  parameter int LEN_W   = 16
) (
  input  logic             clk40,
  input  logic             rst,
  input  logic [7:0]       din,
  input  logic             din_valid,
  input  logic             din_sof,
  input  logic             din_eof,
  output logic             crc_done,
  output logic             crc_ok,
  output logic [1:0]       crc_err,
  output logic [LEN_W-1:0] frame_len,
  output logic [31:0]      crc_residue
`ifdef CRC_STRIP_EN
  ,
  output logic [7:0]       dout,
  output logic             dout_valid,
  output logic             dout_sof,
  output logic             dout_eof
`endif
);

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  crc_state_e       state_q;
  logic [31:0]      crcReg_q;
  logic [LEN_W-1:0] lenCnt_q;
  logic             overflow_q;
  logic             done_q;
  logic             ok_q;
  crc_err_e         err_q;
  logic [LEN_W-1:0] frameLen_q;
  logic [31:0]      residue_q;

  logic             isIdle;
  logic             beatStart;
  logic             beatAbort;
  logic             beatCont;
  logic             beatEnd;
  logic [31:0]      crcSeed_d;
  logic [31:0]      crcNext_d;
  logic [LEN_W-1:0] lenNext_d;
  logic             overflowNext_d;
  logic [LEN_W-1:0] endLen_d;
  crc_err_e         endErr_d;

  // Beat classification. A sof mid-frame aborts the running frame; without
  // eof it also opens the next frame on the same beat. A sof+eof mid-frame
  // only aborts, the lone byte is not reported as a separate frame.
  always_comb begin
    isIdle    = (state_q == ST_IDLE);
    beatStart = din_valid && din_sof && (isIdle || !din_eof);
    beatAbort = din_valid && din_sof && !isIdle;
    beatCont  = din_valid && !din_sof && !isIdle;
    beatEnd   = din_valid && din_eof && (isIdle ? din_sof : !din_sof);
  end

  // A starting beat reseeds from the init value, otherwise keep folding bytes
  // into the running register.
  always_comb begin
    crcSeed_d = beatStart ? CRC_INIT : crcReg_q;
  end

  crc32_byte_step uStep (
    .crc_i  (crcSeed_d),
    .data_i (din),
    .crc_o  (crcNext_d)
  );

  // Length saturates at all-ones; reaching that value flags overflow for the
  // remainder of the frame. A frame ending on its start beat is one byte long.
  always_comb begin
    lenNext_d      = (lenCnt_q == LEN_MAX) ? lenCnt_q : lenCnt_q + LEN_W'(1);
    overflowNext_d = overflow_q || (lenNext_d == LEN_MAX);
    endLen_d       = isIdle ? LEN_W'(1) : lenNext_d;
    endErr_d       = ERR_NONE;
    if (!isIdle && overflowNext_d) begin
      endErr_d = ERR_ABORT;
    end else if (endLen_d < LEN_W'(MIN_LEN)) begin
      endErr_d = ERR_RUNT;
    end else if (crcNext_d != CRC_RESIDUE) begin
      endErr_d = ERR_CRC;
    end
  end

  // Frame FSM with its length counter, CRC register and registered status.
  always_ff @(posedge clk40) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      crcReg_q   <= CRC_INIT;
      lenCnt_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= ERR_NONE;
      frameLen_q <= '0;
      residue_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (beatAbort) begin
        done_q     <= 1'b1;
        ok_q       <= 1'b0;
        err_q      <= ERR_ABORT;
        frameLen_q <= lenCnt_q;
        residue_q  <= crcReg_q;
      end else if (beatEnd) begin
        done_q     <= 1'b1;
        ok_q       <= (endErr_d == ERR_NONE);
        err_q      <= endErr_d;
        frameLen_q <= endLen_d;
        residue_q  <= crcNext_d;
      end

      if (beatStart) begin
        crcReg_q   <= crcNext_d;
        lenCnt_q   <= LEN_W'(1);
        overflow_q <= 1'b0;
        state_q    <= din_eof ? ST_IDLE : ST_ACTIVE;
      end else if (beatAbort) begin
        crcReg_q   <= CRC_INIT;
        lenCnt_q   <= '0;
        overflow_q <= 1'b0;
        state_q    <= ST_IDLE;
      end else if (beatCont) begin
        crcReg_q   <= crcNext_d;
        lenCnt_q   <= lenNext_d;
        overflow_q <= overflowNext_d;
        if (din_eof) begin
          state_q <= ST_IDLE;
        end
      end
    end
  end

  assign crc_done    = done_q;
  assign crc_ok      = ok_q;
  assign crc_err     = err_q;
  assign frame_len   = frameLen_q;
  assign crc_residue = residue_q;

`ifdef CRC_STRIP_EN
  logic [7:0] dly_q [4];
  logic [2:0] dlyCnt_q;
  logic       sentAny_q;
  logic [7:0] dout_q;
  logic       doutValid_q;
  logic       doutSof_q;
  logic       doutEof_q;

  // Four-deep delay line holding back the bytes that might be FCS. Once full,
  // each continuing beat releases the oldest byte; the beat carrying eof
  // releases the last payload byte because the four behind it are the FCS.
  always_ff @(posedge clk40) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        dly_q[i] <= '0;
      end
      dlyCnt_q    <= '0;
      sentAny_q   <= 1'b0;
      dout_q      <= '0;
      doutValid_q <= 1'b0;
      doutSof_q   <= 1'b0;
      doutEof_q   <= 1'b0;
    end else begin
      doutValid_q <= 1'b0;
      doutSof_q   <= 1'b0;
      doutEof_q   <= 1'b0;
      if (beatStart) begin
        dly_q[0]  <= din;
        dlyCnt_q  <= din_eof ? 3'd0 : 3'd1;
        sentAny_q <= 1'b0;
      end else if (beatAbort) begin
        dlyCnt_q <= '0;
      end else if (beatCont) begin
        dly_q[0] <= din;
        for (int i = 1; i < 4; i++) begin
          dly_q[i] <= dly_q[i-1];
        end
        if (dlyCnt_q == 3'd4) begin
          dout_q      <= dly_q[3];
          doutValid_q <= 1'b1;
          doutSof_q   <= !sentAny_q;
          doutEof_q   <= din_eof;
          sentAny_q   <= 1'b1;
        end else begin
          dlyCnt_q <= dlyCnt_q + 3'd1;
        end
        if (din_eof) begin
          dlyCnt_q <= '0;
        end
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = doutValid_q;
  assign dout_sof   = doutSof_q;
  assign dout_eof   = doutEof_q;
`endif

endmodule
